// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared width default, FSM encodings and op codes for the
// two-requester add/sub arbiter.
package addsub_arb_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: combinational WIDTH-bit adder/subtractor. Subtract is done as
// A + ~B + 1, so carry_o = 1 means "no borrow".
module addsub_unit
  import addsub_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] b_x;
  logic             cin;

  // Invert B and inject a carry-in for subtraction.
  always_comb begin
    b_x = (sub_i == OP_ADD) ? b_i : ~b_i;
    cin = (sub_i == OP_SUB);
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one add/sub unit. IDLE grants one
// requester and latches its operands, EXEC computes into the result
// registers, RESP pulses rsp_valid. Grant to response is two cycles.
// Build option ARB_RR_EN: round-robin arbitration between the requesters;
// when undefined requester 0 always wins a simultaneous request.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_sub_q, op_id_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, rsp_id_q;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             pick1;

`ifdef ARB_RR_EN
  // prio_q = 1 means requester 1 wins the next simultaneous request.
  logic prio_q;

  // Pick requester 1 if it alone asks, or both ask and it holds priority.
  always_comb pick1 = req1 & (~req0 | prio_q);

  // After each grant hand priority to the requester that lost out.
  always_ff @(posedge clk) begin
    if (rst)              prio_q <= 1'b0;
    else if (gnt0 | gnt1) prio_q <= gnt0;
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  always_comb pick1 = req1 & ~req0;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on grant, EXEC -> RESP -> IDLE, illegal -> IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = (gnt0 | gnt1) ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: grants only in IDLE and never under reset.
  always_comb begin
    gnt0      = (state_q == ST_IDLE) & ~rst & req0 & ~pick1;
    gnt1      = (state_q == ST_IDLE) & ~rst & pick1;
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_id    = rsp_id_q;
    result    = result_q;
    carry     = carry_q;
  end

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .sub_i   (op_sub_q),
    .sum_o   (sum),
    .carry_o (cout)
  );

  // Latch operands on grant; capture the result at the end of EXEC and
  // hold it until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sub_q <= 1'b0;
      op_id_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      if (gnt0) begin
        op_a_q   <= a0;
        op_b_q   <= b0;
        op_sub_q <= sub0;
        op_id_q  <= 1'b0;
      end else if (gnt1) begin
        op_a_q   <= a1;
        op_b_q   <= b1;
        op_sub_q <= sub1;
        op_id_q  <= 1'b1;
      end
      if (state_q == ST_EXEC) begin
        result_q <= sum;
        carry_q  <= cout;
        rsp_id_q <= op_id_q;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scoreboard bench for addsub_arbiter. Expected responses
// are queued at grant time and checked when rsp_valid appears.
module tb_addsub_arbiter;

  localparam int W = 32;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         c;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, rsp_valid, rsp_id, carry;
  logic [W-1:0] result;

  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  exp_t         sb[$];
  logic         prio_m = 1'b0;
  logic [W:0]   exp0, exp1;
  int           last_gnt = -100;
  logic         prev_rv = 1'b0;
  logic [W-1:0] last_res = '0;
  logic         last_c = 1'b0, last_id = 1'b0;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .result(result), .carry(carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Reference arithmetic written independently of the DUT datapath.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic [63:0] t;
    if (s) return {(a >= b), a - b};
    t = 64'(a) + 64'(b);
    return {t[32], t[31:0]};
  endfunction

  // Per-cycle invariants plus scoreboard pop on every response.
  always @(negedge clk) begin
    n_cmp++;
    if (gnt0 && gnt1) begin
      n_err++; $display("FAIL both_gnt: gnt0=%b gnt1=%b required not both", gnt0, gnt1);
    end
    if ((gnt0 || gnt1) && (busy || rst)) begin
      n_err++; $display("FAIL gnt_outside_idle: busy=%b rst=%b gnt0=%b gnt1=%b", busy, rst, gnt0, gnt1);
    end
    if (!busy && dut.state_q != 2'b00) begin
      n_err++; $display("FAIL busy_state: busy=0 with state=%b required 00", dut.state_q);
    end
    if (rsp_valid) begin
      n_cmp++;
      if (prev_rv) begin
        n_err++; $display("FAIL rsp_twice: rsp_valid high two cycles at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        n_err++; $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with nothing pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_id !== e.id) begin
          n_err++; $display("FAIL rsp_id: got %b required %b", rsp_id, e.id);
        end
        n_cmp++;
        if (result !== e.res) begin
          n_err++; $display("FAIL result: got %h required %h", result, e.res);
        end
        n_cmp++;
        if (carry !== e.c) begin
          n_err++; $display("FAIL carry: got %b required %b", carry, e.c);
        end
        n_cmp++;
        if (cyc !== e.cyc) begin
          n_err++; $display("FAIL latency: rsp at cycle %0d required %0d", cyc, e.cyc);
        end
        last_res = e.res; last_c = e.c; last_id = e.id;
      end
    end
    prev_rv = rsp_valid;
  end

  // Raise the requested reqs, accept grants, queue expectations, then drop
  // each req and scramble its operands to prove they were latched.
  task automatic serve(input logic r0, input logic r1);
    logic p0, p1, win;
    int   budget;
    p0 = r0; p1 = r1; budget = 0;
    req0 = r0; req1 = r1;
    while ((p0 || p1) && budget < 40) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      win = prio_m;
`else
      win = 1'b0;
`endif
      if ((gnt0 && p0) || (gnt1 && p1)) begin
        if (p0 && p1) begin
          n_cmp++;
          if (gnt1 !== win) begin
            n_err++; $display("FAIL arb_winner: granted id %b required %b", gnt1, win);
          end
        end
        n_cmp++;
        if (cyc - last_gnt < 3) begin
          n_err++; $display("FAIL grant_gap: %0d cycles required >= 3", cyc - last_gnt);
        end
        last_gnt = cyc;
        if (gnt0) begin
          sb.push_back('{id: 1'b0, res: exp0[W-1:0], c: exp0[W], cyc: cyc + 2});
          prio_m = 1'b1; p0 = 1'b0;
        end else begin
          sb.push_back('{id: 1'b1, res: exp1[W-1:0], c: exp1[W], cyc: cyc + 2});
          prio_m = 1'b0; p1 = 1'b0;
        end
      end else if (gnt0 || gnt1) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_gnt: gnt0=%b gnt1=%b pending %b%b", gnt0, gnt1, p0, p1);
      end
      @(posedge clk); #1;
      if (!p0 && req0) begin req0 = 1'b0; a0 = $urandom; b0 = $urandom; sub0 = ~sub0; end
      if (!p1 && req1) begin req1 = 1'b0; a1 = $urandom; b1 = $urandom; sub1 = ~sub1; end
      budget++;
    end
    if (p0 || p1) begin
      n_cmp++; n_err++;
      $display("FAIL grant_timeout: pending %b%b required granted", p0, p1);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 10) begin
      @(posedge clk); #1; budget++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rsp_timeout: %0d responses outstanding required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1, busy, rsp_valid, rsp_id, carry} !== 6'b0 || result !== '0) begin
        n_err++;
        $display("FAIL reset_state: gnt=%b%b busy=%b rv=%b id=%b c=%b res=%h required all 0",
                 gnt0, gnt1, busy, rsp_valid, rsp_id, carry, result);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b0; prio_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    a0 = 32'd1426; b0 = 32'd3803; sub0 = 1'b0; exp0 = {1'b0, 32'd5229};
    serve(1'b1, 1'b0); drain();
    a1 = 32'd1426; b1 = 32'd3803; sub1 = 1'b1; exp1 = {1'b0, 32'hFFFFF6B7};
    serve(1'b0, 1'b1); drain();
  endtask

  task automatic test_contest();
    a0 = 32'd3251; b0 = 32'd2489; sub0 = 1'b0; exp0 = {1'b0, 32'd5740};
    a1 = 32'd3251; b1 = 32'd2489; sub1 = 1'b1; exp1 = {1'b1, 32'd762};
    serve(1'b1, 1'b1); drain();
    a0 = 32'd10; b0 = 32'd20; sub0 = 1'b0; exp0 = {1'b0, 32'd30};
    serve(1'b1, 1'b0); drain();
    a0 = 32'd3251; b0 = 32'd2489; sub0 = 1'b0; exp0 = {1'b0, 32'd5740};
    a1 = 32'd3251; b1 = 32'd2489; sub1 = 1'b1; exp1 = {1'b1, 32'd762};
    serve(1'b1, 1'b1); drain();
  endtask

  task automatic test_edges();
    a0 = 32'hFFFFFFFF; b0 = 32'd1; sub0 = 1'b0; exp0 = {1'b1, 32'h0};
    serve(1'b1, 1'b0); drain();
    a0 = 32'h7FFFFFFF; b0 = 32'd1; sub0 = 1'b0; exp0 = {1'b0, 32'h80000000};
    serve(1'b1, 1'b0); drain();
    a1 = 32'd5; b1 = 32'd5; sub1 = 1'b1; exp1 = {1'b1, 32'h0};
    serve(1'b0, 1'b1); drain();
  endtask

  task automatic test_hold();
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (result !== last_res || carry !== last_c || rsp_id !== last_id) begin
        n_err++;
        $display("FAIL hold: res=%h c=%b id=%b required %h %b %b",
                 result, carry, rsp_id, last_res, last_c, last_id);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int budget;
    logic seen;
    a0 = 32'd100; b0 = 32'd23; sub0 = 1'b0; req0 = 1'b1;
    budget = 0; seen = 1'b0;
    while (!seen && budget < 10) begin
      @(negedge clk);
      seen = gnt0;
      budget++;
      if (!seen) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL abort_grant: gnt0 not seen required 1");
    end
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b1;
    a1 = 32'd40; b1 = 32'd2; sub1 = 1'b1; exp1 = {1'b1, 32'd38};
    @(negedge clk);
    n_cmp++;
    if (gnt1 !== 1'b0) begin
      n_err++; $display("FAIL rst_gnt: gnt1=%b required 0", gnt1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({busy, rsp_valid, rsp_id, carry, gnt1} !== 5'b0 || result !== '0) begin
      n_err++;
      $display("FAIL abort_state: busy=%b rv=%b id=%b c=%b gnt1=%b res=%h required all 0",
               busy, rsp_valid, rsp_id, carry, gnt1, result);
    end
    @(posedge clk); #1;
    rst = 1'b0; prio_m = 1'b0; last_gnt = -100;
    serve(1'b0, 1'b1); drain();
  endtask

  task automatic test_back_to_back();
    logic r0, r1;
    for (int i = 0; i < 10; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = (r0 == 1'b0) ? 1'b1 : 1'($urandom_range(0, 1));
      a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom_range(0, 1));
      a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom_range(0, 1));
      exp0 = model(a0, b0, sub0);
      exp1 = model(a1, b1, sub1);
      serve(r0, r1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contest();
    test_edges();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
